// File: rtl/resource_arbiter_q.sv
// FIFO-ordered arbiter: requesters are queued once in arrival order and the
// queue head receives an exclusive one-hot grant until it drops its request.
module resource_arbiter_q #(
  parameter int NREQ   = 4,
  parameter int QDEPTH = 4,
  parameter int IDXW   = $clog2(NREQ)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NREQ-1:0]              request,
  output logic [NREQ-1:0]              grant,
  output logic                         grant_valid,
  output logic [IDXW-1:0]              owner,
  output logic [$clog2(QDEPTH+1)-1:0]  queue_count,
  output logic                         queue_full
);

  localparam int CNTW = $clog2(QDEPTH + 1);
  localparam int PTRW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [NREQ-1:0]   grant_r, grant_nxt_s;
  logic              grant_valid_r, grant_valid_nxt_s;
  logic [IDXW-1:0]   owner_r, owner_nxt_s;
  logic [NREQ-1:0]   pending_r, pending_nxt_s;
  logic [NREQ-1:0]   elig_s;
  logic [IDXW-1:0]   enq_idx_s, head_idx_s;
  logic [IDXW-1:0]   queue_r [QDEPTH];
  logic [PTRW-1:0]   head_r, tail_r;
  logic [CNTW-1:0]   count_r, count_nxt_s;
  logic              queue_full_r;
  logic              release_s, pop_s, head_live_s, enq_s;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(QDEPTH - 1)) ? {PTRW{1'b0}} : p + 1'b1;
  endfunction

  // Enqueue eligibility, pop decision and next-state/grant logic.
  always_comb begin
    elig_s            = {NREQ{1'b0}};
    enq_idx_s         = {IDXW{1'b0}};
    state_nxt_s       = state_r;
    grant_nxt_s       = grant_r;
    grant_valid_nxt_s = grant_valid_r;
    owner_nxt_s       = owner_r;
    pending_nxt_s     = pending_r;
    count_nxt_s       = count_r;

    for (int i = 0; i < NREQ; i++) begin
      elig_s[i] = request[i] & ~pending_r[i] & ~(grant_valid_r && (owner_r == IDXW'(i)));
    end
    // Descending scan so the lowest eligible index is the one left standing.
    for (int i = NREQ - 1; i >= 0; i--) begin
      enq_idx_s = elig_s[i] ? IDXW'(i) : enq_idx_s;
    end

    head_idx_s  = queue_r[head_r];
    release_s   = (state_r == ST_GRANT) && !request[owner_r];
    pop_s       = (count_r != {CNTW{1'b0}}) && ((state_r == ST_IDLE) || release_s);
    head_live_s = pop_s && request[head_idx_s];
    enq_s       = (|elig_s) && ((count_r != CNTW'(QDEPTH)) || pop_s);

    case ({enq_s, pop_s})
      2'b10:   count_nxt_s = count_r + 1'b1;
      2'b01:   count_nxt_s = count_r - 1'b1;
      default: count_nxt_s = count_r;
    endcase

    case (state_r)
      ST_IDLE: begin
        if (head_live_s) begin
          state_nxt_s       = ST_GRANT;
          grant_nxt_s       = ONE_HOT0 << head_idx_s;
          grant_valid_nxt_s = 1'b1;
          owner_nxt_s       = head_idx_s;
        end else if (pop_s) begin
          pending_nxt_s[head_idx_s] = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          pending_nxt_s[owner_r] = 1'b0;
          if (head_live_s) begin
            grant_nxt_s = ONE_HOT0 << head_idx_s;
            owner_nxt_s = head_idx_s;
          end else begin
            // A stale head is dropped here; the next head is examined from IDLE.
            state_nxt_s       = ST_IDLE;
            grant_nxt_s       = {NREQ{1'b0}};
            grant_valid_nxt_s = 1'b0;
            owner_nxt_s       = {IDXW{1'b0}};
            if (pop_s) begin
              pending_nxt_s[head_idx_s] = 1'b0;
            end else begin
              pending_nxt_s[owner_r] = 1'b0;
            end
          end
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: begin
        state_nxt_s       = ST_IDLE;
        grant_nxt_s       = {NREQ{1'b0}};
        grant_valid_nxt_s = 1'b0;
        owner_nxt_s       = {IDXW{1'b0}};
      end
    endcase

    if (enq_s) begin
      pending_nxt_s[enq_idx_s] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      grant_r       <= {NREQ{1'b0}};
      grant_valid_r <= 1'b0;
      owner_r       <= {IDXW{1'b0}};
      pending_r     <= {NREQ{1'b0}};
      head_r        <= {PTRW{1'b0}};
      tail_r        <= {PTRW{1'b0}};
      count_r       <= {CNTW{1'b0}};
      queue_full_r  <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      grant_r       <= grant_nxt_s;
      grant_valid_r <= grant_valid_nxt_s;
      owner_r       <= owner_nxt_s;
      pending_r     <= pending_nxt_s;
      count_r       <= count_nxt_s;
      queue_full_r  <= (count_nxt_s == CNTW'(QDEPTH));
      if (pop_s) head_r <= ptr_inc(head_r);
      if (enq_s) tail_r <= ptr_inc(tail_r);
    end
  end

  // Queue storage; contents are meaningless outside the head..tail window.
  always_ff @(posedge clock) begin
    if (enq_s && !reset) queue_r[tail_r] <= enq_idx_s;
  end

  assign grant       = grant_r;
  assign grant_valid = grant_valid_r;
  assign owner       = owner_r;
  assign queue_count = count_r;
  assign queue_full  = queue_full_r;

endmodule

// File: tb/tb_resource_arbiter_q.sv
// Directed bench for resource_arbiter_q: a 4x4 instance for most scenarios and
// a 4-requester, 2-entry instance for queue saturation.
module tb_resource_arbiter_q;

  logic       clock;
  logic       reset;
  logic [3:0] request, request2;
  logic [3:0] grant, grant2;
  logic       grant_valid, grant_valid2;
  logic [1:0] owner, owner2;
  logic [2:0] queue_count;
  logic [1:0] queue_count2;
  logic       queue_full, queue_full2;

  int checks = 0;
  int failures = 0;

  resource_arbiter_q #(.NREQ(4), .QDEPTH(4)) dut (
    .clock(clock), .reset(reset), .request(request), .grant(grant),
    .grant_valid(grant_valid), .owner(owner), .queue_count(queue_count),
    .queue_full(queue_full)
  );

  resource_arbiter_q #(.NREQ(4), .QDEPTH(2)) dut2 (
    .clock(clock), .reset(reset), .request(request2), .grant(grant2),
    .grant_valid(grant_valid2), .owner(owner2), .queue_count(queue_count2),
    .queue_full(queue_full2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; request = 4'b0000; request2 = 4'b0000;
    cyc(2);
    reset = 1'b0;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL reset_gv got=%b exp=0", grant_valid); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    checks++; if (queue_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", queue_count); end
    checks++; if (queue_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", queue_full); end
    checks++; if (grant2 !== 4'b0000 || queue_count2 !== 2'd0) begin failures++; $display("FAIL reset_dut2 got=%b/%0d exp=0000/0", grant2, queue_count2); end
  endtask

  task automatic test_single();
    request = 4'b0001;
    cyc(1);
    checks++; if (queue_count !== 3'd1) begin failures++; $display("FAIL single_enq_count got=%0d exp=1", queue_count); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_no_grant_yet got=%b exp=0000", grant); end
    cyc(1);
    checks++; if (grant !== 4'b0001 || owner !== 2'd0 || grant_valid !== 1'b1) begin failures++; $display("FAIL single_grant got=%b/%0d/%b exp=0001/0/1", grant, owner, grant_valid); end
    checks++; if (queue_count !== 3'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", queue_count); end
    cyc(3);
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL single_hold got=%b exp=0001", grant); end
    request = 4'b0000;
    cyc(1);
    checks++; if (grant !== 4'b0000 || grant_valid !== 1'b0 || owner !== 2'd0) begin failures++; $display("FAIL single_release got=%b/%b/%0d exp=0000/0/0", grant, grant_valid, owner); end
  endtask

  task automatic test_handover();
    request = 4'b1111;
    cyc(1);
    checks++; if (queue_count !== 3'd1) begin failures++; $display("FAIL ho_enq0 got=%0d exp=1", queue_count); end
    cyc(1);
    checks++; if (grant !== 4'b0001 || queue_count !== 3'd1) begin failures++; $display("FAIL ho_grant0 got=%b/%0d exp=0001/1", grant, queue_count); end
    cyc(1);
    checks++; if (queue_count !== 3'd2) begin failures++; $display("FAIL ho_enq2 got=%0d exp=2", queue_count); end
    cyc(2);
    checks++; if (queue_count !== 3'd3) begin failures++; $display("FAIL ho_enq3 got=%0d exp=3", queue_count); end
    request = 4'b1110;
    cyc(1);
    checks++; if (grant !== 4'b0010 || owner !== 2'd1 || queue_count !== 3'd2) begin failures++; $display("FAIL ho_to1 got=%b/%0d/%0d exp=0010/1/2", grant, owner, queue_count); end
    request = 4'b1100;
    cyc(1);
    checks++; if (grant !== 4'b0100 || owner !== 2'd2) begin failures++; $display("FAIL ho_to2 got=%b/%0d exp=0100/2", grant, owner); end
    request = 4'b1000;
    cyc(1);
    checks++; if (grant !== 4'b1000 || owner !== 2'd3 || queue_count !== 3'd0) begin failures++; $display("FAIL ho_to3 got=%b/%0d/%0d exp=1000/3/0", grant, owner, queue_count); end
    request = 4'b0000;
    cyc(1);
    checks++; if (grant !== 4'b0000 || grant_valid !== 1'b0) begin failures++; $display("FAIL ho_end got=%b/%b exp=0000/0", grant, grant_valid); end
  endtask

  task automatic test_queue_full();
    request2 = 4'b1111;
    cyc(3);
    checks++; if (queue_count2 !== 2'd2 || queue_full2 !== 1'b1) begin failures++; $display("FAIL qf_saturate got=%0d/%b exp=2/1", queue_count2, queue_full2); end
    checks++; if (grant2 !== 4'b0001) begin failures++; $display("FAIL qf_owner0 got=%b exp=0001", grant2); end
    cyc(1);
    checks++; if (queue_count2 !== 2'd2) begin failures++; $display("FAIL qf_no_overflow got=%0d exp=2", queue_count2); end
    request2 = 4'b1110;
    cyc(1);
    checks++; if (grant2 !== 4'b0010 || queue_count2 !== 2'd2 || queue_full2 !== 1'b1) begin failures++; $display("FAIL qf_to1 got=%b/%0d/%b exp=0010/2/1", grant2, queue_count2, queue_full2); end
    request2 = 4'b1100;
    cyc(1);
    checks++; if (grant2 !== 4'b0100 || queue_count2 !== 2'd1 || queue_full2 !== 1'b0) begin failures++; $display("FAIL qf_to2 got=%b/%0d/%b exp=0100/1/0", grant2, queue_count2, queue_full2); end
    request2 = 4'b1000;
    cyc(1);
    checks++; if (grant2 !== 4'b1000 || queue_count2 !== 2'd0) begin failures++; $display("FAIL qf_to3 got=%b/%0d exp=1000/0", grant2, queue_count2); end
    request2 = 4'b0000;
    cyc(1);
    checks++; if (grant2 !== 4'b0000 || queue_count2 !== 2'd0) begin failures++; $display("FAIL qf_end got=%b/%0d exp=0000/0", grant2, queue_count2); end
  endtask

  task automatic test_discard();
    request = 4'b0001;
    cyc(2);
    request = 4'b1101;
    cyc(2);
    checks++; if (queue_count !== 3'd2 || grant !== 4'b0001) begin failures++; $display("FAIL dis_setup got=%0d/%b exp=2/0001", queue_count, grant); end
    request = 4'b1001;
    cyc(1);
    checks++; if (grant !== 4'b0001 || queue_count !== 3'd2) begin failures++; $display("FAIL dis_drop2 got=%b/%0d exp=0001/2", grant, queue_count); end
    request = 4'b1000;
    cyc(1);
    checks++; if (grant !== 4'b0000 || queue_count !== 3'd1) begin failures++; $display("FAIL dis_pop2 got=%b/%0d exp=0000/1", grant, queue_count); end
    cyc(1);
    checks++; if (grant !== 4'b1000 || owner !== 2'd3 || queue_count !== 3'd0) begin failures++; $display("FAIL dis_next3 got=%b/%0d/%0d exp=1000/3/0", grant, owner, queue_count); end
    request = 4'b1100;
    cyc(1);
    checks++; if (queue_count !== 3'd1) begin failures++; $display("FAIL dis_reenq2 got=%0d exp=1", queue_count); end
    request = 4'b0100;
    cyc(1);
    checks++; if (grant !== 4'b0100 || owner !== 2'd2) begin failures++; $display("FAIL dis_grant2 got=%b/%0d exp=0100/2", grant, owner); end
    request = 4'b0000;
    cyc(1);
    checks++; if (grant !== 4'b0000 || queue_count !== 3'd0) begin failures++; $display("FAIL dis_end got=%b/%0d exp=0000/0", grant, queue_count); end
  endtask

  task automatic test_reset_mid_grant();
    request = 4'b0010;
    cyc(2);
    request = 4'b0111;
    cyc(2);
    checks++; if (grant !== 4'b0010 || queue_count !== 3'd2) begin failures++; $display("FAIL rst_setup got=%b/%0d exp=0010/2", grant, queue_count); end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    checks++; if (grant !== 4'b0000 || queue_count !== 3'd0 || grant_valid !== 1'b0) begin failures++; $display("FAIL rst_mid got=%b/%0d/%b exp=0000/0/0", grant, queue_count, grant_valid); end
    cyc(1);
    checks++; if (queue_count !== 3'd1 || grant !== 4'b0000) begin failures++; $display("FAIL rst_reenq got=%0d/%b exp=1/0000", queue_count, grant); end
    cyc(1);
    checks++; if (grant !== 4'b0001 || owner !== 2'd0) begin failures++; $display("FAIL rst_lowest_first got=%b/%0d exp=0001/0", grant, owner); end
    request = 4'b0000;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  task automatic test_hold();
    logic [2:0] pend_m;
    logic [2:0] elig_m;
    logic [3:0] req_v;
    int         cnt_m;
    bit         taken;
    int         bad;
    request = 4'b1000;
    cyc(2);
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL hold_setup got=%b exp=1000", grant); end
    pend_m = 3'b000; cnt_m = 0; bad = 0;
    for (int k = 0; k < 50; k++) begin
      req_v = {1'b1, k[2:0]};
      request = req_v;
      cyc(1);
      elig_m = req_v[2:0] & ~pend_m;
      taken = 1'b0;
      for (int j = 0; j < 3; j++) begin
        if (elig_m[j] && !taken) begin
          pend_m[j] = 1'b1; cnt_m++; taken = 1'b1;
        end
      end
      checks++;
      if (grant !== 4'b1000 || queue_count !== 3'(cnt_m)) begin
        failures++;
        $display("FAIL hold_cycle%0d got=%b/%0d exp=1000/%0d", k, grant, queue_count, cnt_m);
      end
    end
    request = 4'b0000;
    cyc(4);
    checks++; if (grant !== 4'b0000 || queue_count !== 3'd0) begin failures++; $display("FAIL hold_drain got=%b/%0d exp=0000/0", grant, queue_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; request = 4'b0000; request2 = 4'b0000;
    test_reset();
    test_single();
    test_handover();
    test_queue_full();
    test_discard();
    test_reset_mid_grant();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
